spi_slave_core: RTL and testbench

- Parametrised, system-clocked SPI slave. Successor to the bare sclk-edge shift slave.
- Oversamples external sclk/ss/mosi in the clk domain. Supports all four SPI modes, configurable word width and bit order, and back-to-back words within one ss assertion.
- Exposes a parallel rx strobe and a tx holding register with a ready/load handshake. Sits between the board-level SPI pins and the register/control logic.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/sync2.sv | 24 ++
 rtl/spi_slave_core.sv | 152 +++++++++++++++
 tb/tb_spi_slave_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types, mode encodings and edge-selection helper for the SPI slave.
package spi_pkg;

  // {CPOL,CPHA} encodings of the four SPI modes
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // Returns 1 when the sample edge is the rising sclk edge.
  // Leading edge is rising for CPOL=0; sampling on leading needs CPHA=0.
  function automatic logic sample_on_rising(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-high reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave: all four modes, configurable width and bit order,
// back-to-back words within one ss window, tx holding register handshake.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int              CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(DATA_W - 1);
  localparam logic            SAMPLE_RISE = sample_on_rising(1'(CPOL), 1'(CPHA));

  logic              sclk_s, ss_s, mosi_s, sclk_d;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rx_sh, rx_next;
  logic [DATA_W-1:0] tx_sh, tx_shifted;
  logic [DATA_W-1:0] hold;
  logic              unr_pend;
  logic              rise, fall, sample_ev, shift_ev;
  logic              entry, abort, word_done, start, consume;

  sync2 #(.RST_VAL(1'(CPOL))) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sync2 #(.RST_VAL(1'b1))     u_sync_ss   (.clk(clk), .rst(rst), .d(ss),   .q(ss_s));
  sync2 #(.RST_VAL(1'b0))     u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  // Delayed copy of synchronised sclk for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sclk_d <= 1'(CPOL);
    else     sclk_d <= sclk_s;
  end

  // Edge classification, word boundaries and shift-register next values
  always_comb begin
    rise       = sclk_s & ~sclk_d;
    fall       = ~sclk_s & sclk_d;
    sample_ev  = (state == ACTIVE) && !ss_s && (SAMPLE_RISE ? rise : fall);
    shift_ev   = (state == ACTIVE) && !ss_s && (SAMPLE_RISE ? fall : rise);
    entry      = (state == IDLE) && !ss_s;
    abort      = (state == ACTIVE) && ss_s;
    word_done  = sample_ev && (cnt == LAST);
    start      = entry || word_done;
    consume    = start && !tx_ready;
    if (MSB_FIRST != 0) begin
      rx_next    = {rx_sh[DATA_W-2:0], mosi_s};
      tx_shifted = {tx_sh[DATA_W-2:0], 1'b0};
    end else begin
      rx_next    = {mosi_s, rx_sh[DATA_W-1:1]};
      tx_shifted = {1'b0, tx_sh[DATA_W-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: follows synchronised ss
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!ss_s) state_nxt = ACTIVE;
      ACTIVE:  if (ss_s)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register handshake: a word-start consume takes priority,
  // and a same-cycle load refills the register straight away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      tx_ready <= 1'b1;
    end else if (consume) begin
      if (tx_load) hold <= tx_data;
      tx_ready <= !tx_load;
    end else if (tx_load && tx_ready) begin
      hold     <= tx_data;
      tx_ready <= 1'b0;
    end
  end

  // Shift datapath, bit counter, rx word capture and strobes.
  // The next word is preloaded when a word completes so its first bit is on
  // miso before the master samples it; an empty holding register at that
  // point only flags underrun once the master actually clocks that word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      unr_pend    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (abort) begin
        cnt      <= '0;
        rx_sh    <= '0;
        tx_sh    <= '0;
        unr_pend <= 1'b0;
      end else begin
        if (start) tx_sh <= tx_ready ? '0 : hold;
        else if (shift_ev && cnt != '0) tx_sh <= tx_shifted;
        if (entry) tx_underrun <= tx_ready;
        if (sample_ev) begin
          rx_sh <= rx_next;
          if (cnt == '0 && unr_pend) begin
            tx_underrun <= 1'b1;
            unr_pend    <= 1'b0;
          end
          if (cnt == LAST) begin
            cnt      <= '0;
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            unr_pend <= tx_ready;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

  // Serial output and status
  always_comb begin
    busy = (state == ACTIVE);
    miso = 1'b0;
    if (busy) miso = (MSB_FIRST != 0) ? tx_sh[DATA_W-1] : tx_sh[0];
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: a mode-0 MSB-first 8-bit slave and a mode-3 LSB-first
// 16-bit slave, each driven by a behavioural SPI master.
module tb_spi_slave_core;

  localparam time HALF = 60ns;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0, miso0;
  logic [7:0]  tx_data0 = '0, rx_data0;
  logic        tx_load0 = 1'b0, tx_ready0, rx_valid0, tx_underrun0, busy0;

  logic        sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0, miso1;
  logic [15:0] tx_data1 = '0, rx_data1;
  logic        tx_load1 = 1'b0, tx_ready1, rx_valid1, tx_underrun1, busy1;

  int checks = 0;
  int failures = 0;
  int vcnt0 = 0, ucnt0 = 0, vcnt1 = 0, ucnt1 = 0;
  logic [7:0] rxq0[$];

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss0), .mosi(mosi0), .miso(miso0),
    .tx_data(tx_data0), .tx_load(tx_load0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_underrun(tx_underrun0), .busy(busy0)
  );

  spi_slave_core #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso1),
    .tx_data(tx_data1), .tx_load(tx_load1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_underrun(tx_underrun1), .busy(busy1)
  );

  // Strobe monitors, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rx_valid0) begin
      vcnt0++;
      rxq0.push_back(rx_data0);
    end
    if (tx_underrun0) ucnt0++;
    if (rx_valid1) vcnt1++;
    if (tx_underrun1) ucnt1++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load0(input logic [7:0] d);
    for (int i = 0; i < 50 && !tx_ready0; i++) @(negedge clk);
    chk("load0_ready_wait", 32'(tx_ready0), 32'd1);
    tx_data0 = d;
    tx_load0 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0;
  endtask

  task automatic load1(input logic [15:0] d);
    for (int i = 0; i < 50 && !tx_ready1; i++) @(negedge clk);
    chk("load1_ready_wait", 32'(tx_ready1), 32'd1);
    tx_data1 = d;
    tx_load1 = 1'b1;
    @(negedge clk);
    tx_load1 = 1'b0;
  endtask

  // Mode 0 MSB-first master: drive before rising edge, sample miso on rising
  task automatic word0(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi0 = tx[i];
      #(HALF);
      sclk0 = 1'b1;
      rx[i] = miso0;
      #(HALF);
      sclk0 = 1'b0;
    end
  endtask

  // Mode 3 LSB-first master: drive on falling (leading), sample on rising
  task automatic word1(input logic [15:0] tx, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < 16; i++) begin
      sclk1 = 1'b0;
      mosi1 = tx[i];
      #(HALF);
      sclk1 = 1'b1;
      rx[i] = miso1;
      #(HALF);
    end
  endtask

  task automatic sel0_low;
    ss0 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sel0_high;
    repeat (4) @(negedge clk);
    ss0 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] ldv;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_unr;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [7:0]  got, got2;
    logic [15:0] got16;
    int bv, bu;

    vt[0] = '{ld: 1'b1, ldv: 8'h3C, mosi: 8'hA5, exp_miso: 8'h3C, exp_unr: 0};
    vt[1] = '{ld: 1'b0, ldv: 8'h00, mosi: 8'h55, exp_miso: 8'h00, exp_unr: 1};
    vt[2] = '{ld: 1'b1, ldv: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_unr: 0};
    vt[3] = '{ld: 1'b1, ldv: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_unr: 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso0), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready0), 32'd1);
    chk("rst_rx_data", 32'(rx_data0), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
    chk("rst_underrun", 32'(tx_underrun0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_tx_ready1", 32'(tx_ready1), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven single-word transfers
    for (int v = 0; v < 4; v++) begin
      bv = vcnt0;
      bu = ucnt0;
      if (vt[v].ld) begin
        load0(vt[v].ldv);
        chk("vec_tx_ready_low", 32'(tx_ready0), 32'd0);
      end
      sel0_low();
      chk("vec_busy", 32'(busy0), 32'd1);
      word0(vt[v].mosi, 8, got);
      sel0_high();
      chk("vec_miso_word", 32'(got), 32'(vt[v].exp_miso));
      chk("vec_rx_data", 32'(rx_data0), 32'(vt[v].mosi));
      chk("vec_rx_valid_pulses", 32'(vcnt0 - bv), 32'd1);
      chk("vec_underrun_pulses", 32'(ucnt0 - bu), 32'(vt[v].exp_unr));
      chk("vec_tx_ready_back", 32'(tx_ready0), 32'd1);
      chk("vec_busy_end", 32'(busy0), 32'd0);
    end

    // Load while holding register full is ignored
    load0(8'h3C);
    tx_data0 = 8'h99;
    tx_load0 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0;
    sel0_low();
    word0(8'h5A, 8, got);
    sel0_high();
    chk("ignored_load_miso", 32'(got), 32'h3C);
    chk("ignored_load_rx", 32'(rx_data0), 32'h5A);

    // Back-to-back words in one ss window
    bv = vcnt0;
    bu = ucnt0;
    rxq0.delete();
    load0(8'h11);
    sel0_low();
    load0(8'h22);
    word0(8'hF0, 8, got);
    word0(8'h0F, 8, got2);
    sel0_high();
    chk("b2b_valid_count", 32'(rxq0.size()), 32'd2);
    if (rxq0.size() == 2) begin
      chk("b2b_rx0", 32'(rxq0[0]), 32'hF0);
      chk("b2b_rx1", 32'(rxq0[1]), 32'h0F);
    end
    chk("b2b_miso0", 32'(got), 32'h11);
    chk("b2b_miso1", 32'(got2), 32'h22);
    chk("b2b_underrun", 32'(ucnt0 - bu), 32'd0);
    chk("b2b_tx_ready", 32'(tx_ready0), 32'd1);

    // Abort after 5 bits; holding register loaded mid-word must survive
    bv = vcnt0;
    sel0_low();
    load0(8'h6D);
    word0(8'hC3, 5, got);
    sel0_high();
    chk("abort_no_valid", 32'(vcnt0 - bv), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_hold_kept", 32'(tx_ready0), 32'd0);
    bv = vcnt0;
    sel0_low();
    word0(8'h81, 8, got);
    sel0_high();
    chk("abort_next_rx", 32'(rx_data0), 32'h81);
    chk("abort_next_valid", 32'(vcnt0 - bv), 32'd1);
    chk("abort_next_miso", 32'(got), 32'h6D);

    // Mode 3, LSB first, 16-bit
    bv = vcnt1;
    bu = ucnt1;
    load1(16'hBEEF);
    ss1 = 1'b0;
    repeat (8) @(negedge clk);
    word1(16'h1234, got16);
    repeat (4) @(negedge clk);
    ss1 = 1'b1;
    repeat (8) @(negedge clk);
    chk("m3_rx_data", 32'(rx_data1), 32'h1234);
    chk("m3_miso_word", 32'(got16), 32'hBEEF);
    chk("m3_valid_pulses", 32'(vcnt1 - bv), 32'd1);
    chk("m3_underrun", 32'(ucnt1 - bu), 32'd0);
    chk("m3_tx_ready", 32'(tx_ready1), 32'd1);

    // Reset mid-word
    bv = vcnt0;
    load0(8'hA0);
    sel0_low();
    word0(8'hF0, 4, got);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(miso0), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready0), 32'd1);
    chk("midrst_rx_data", 32'(rx_data0), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid0), 32'd0);
    chk("midrst_underrun", 32'(tx_underrun0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_rx_data1", 32'(rx_data1), 32'd0);
    @(negedge clk);
    ss0 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_valid", 32'(vcnt0 - bv), 32'd0);
    bv = vcnt0;
    bu = ucnt0;
    sel0_low();
    word0(8'h7E, 8, got);
    sel0_high();
    chk("postrst_rx", 32'(rx_data0), 32'h7E);
    chk("postrst_valid", 32'(vcnt0 - bv), 32'd1);
    chk("postrst_miso", 32'(got), 32'h00);
    chk("postrst_underrun", 32'(ucnt0 - bu), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
